// File: rtl/spi_fsm_if.sv
// Control bundle between the SPI front end and the transaction sequencer.
// The host side (master) drives the conditioned SPI inputs; the sequencer drives strobes.
interface spi_fsm_if;
  logic       sclk_pos;
  logic       cs_cond;
  logic       rw_bit;
  logic       sr_we;
  logic       addr_we;
  logic       dm_we;
  logic       miso_en;
  logic       abort;
  logic [3:0] state_out;

  modport master (
    output sclk_pos, cs_cond, rw_bit,
    input  sr_we, addr_we, dm_we, miso_en, abort, state_out
  );

  modport slave (
    input  sclk_pos, cs_cond, rw_bit,
    output sr_we, addr_we, dm_we, miso_en, abort, state_out
  );
endinterface

// File: rtl/spi_fsm_controller.sv
// SPI memory transaction sequencer: counts SCLK pulses under CS and
// drives the datapath load/latch/write/tri-state strobes.
module spi_fsm_controller #(
  parameter int FRAME_BITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic     clk,
  input  logic     reset,
  spi_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    GET_ADDR     = 4'd1,
    GOT_ADDR     = 4'd2,
    READ_WAIT    = 4'd3,
    READ_LOAD    = 4'd4,
    READ_SHIFT   = 4'd5,
    WRITE_SHIFT  = 4'd6,
    WRITE_COMMIT = 4'd7,
    DONE         = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.cs_cond) begin
          state_d = GET_ADDR;
          cnt_d   = '0;
        end
      end
      GET_ADDR: begin
        if (bus.cs_cond) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (bus.sclk_pos) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = GOT_ADDR;
        end
      end
      GOT_ADDR: begin
        if (bus.cs_cond) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (bus.rw_bit) begin
          state_d = READ_WAIT;
        end else begin
          state_d = WRITE_SHIFT;
          cnt_d   = '0;
        end
      end
      READ_WAIT: begin
        if (bus.cs_cond) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else begin
          state_d = READ_LOAD;
        end
      end
      READ_LOAD: begin
        cnt_d = '0;
        if (bus.cs_cond) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = READ_SHIFT;
        end
      end
      READ_SHIFT, WRITE_SHIFT: begin
        if (bus.cs_cond) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (bus.sclk_pos) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST)
            state_d = (state_q == READ_SHIFT) ? DONE : WRITE_COMMIT;
        end
      end
      // the write is already committed this cycle, so CS rising is not an abort
      WRITE_COMMIT: state_d = bus.cs_cond ? IDLE : DONE;
      DONE:         if (bus.cs_cond) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.addr_we   = (state_q == GOT_ADDR);
  assign bus.sr_we     = (state_q == READ_LOAD);
  assign bus.miso_en   = (state_q == READ_SHIFT);
  assign bus.dm_we     = (state_q == WRITE_COMMIT);
  assign bus.abort     = abort_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Self-checking bench for spi_fsm_controller: directed scenarios plus
// randomized frames checked against a frame-level strobe model.
module tb_spi_fsm_controller;

  logic clk = 1'b0;
  logic reset;
  spi_fsm_if bus ();

  spi_fsm_controller #(.FRAME_BITS(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_addr, n_sr, n_dm, n_miso, n_abort;

  always @(negedge clk) begin
    if (!reset) begin
      n_addr  += int'(bus.addr_we);
      n_sr    += int'(bus.sr_we);
      n_dm    += int'(bus.dm_we);
      n_miso  += int'(bus.miso_en);
      n_abort += int'(bus.abort);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_addr = 0; n_sr = 0; n_dm = 0; n_miso = 0; n_abort = 0;
  endtask

  task automatic pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) tick();
      bus.sclk_pos = 1'b1;
      tick();
      bus.sclk_pos = 1'b0;
    end
  endtask

  // CS low, then the 8 address-phase pulses; ends in the GOT_ADDR cycle
  task automatic addr_phase(input logic rd, input int gap);
    bus.cs_cond = 1'b0;
    bus.rw_bit  = 1'($urandom % 2);
    tick();
    pulses(7, gap);
    bus.rw_bit = rd;
    pulses(1, gap);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests++;
    if (bus.state_out !== 4'd0 || bus.miso_en !== 1'b0 || bus.abort !== 1'b0) begin
      fails++;
      $display("FAIL reset_init state=%0d miso=%b abort=%b want 0/0/0", bus.state_out, bus.miso_en, bus.abort);
    end
    tick();
    reset = 1'b0;
    tick();
    addr_phase(1'b1, 0);
    repeat (3) tick();
    pulses(3, 0);
    tests++;
    if (bus.state_out !== 4'd5 || bus.miso_en !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre state=%0d miso=%b want 5/1", bus.state_out, bus.miso_en);
    end
    #1 reset = 1'b1;
    bus.cs_cond = 1'b1;
    #1;
    tests++;
    if (bus.state_out !== 4'd0 || bus.miso_en !== 1'b0 || bus.abort !== 1'b0) begin
      fails++;
      $display("FAIL reset_async state=%0d miso=%b abort=%b want 0/0/0", bus.state_out, bus.miso_en, bus.abort);
    end
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if (bus.state_out !== 4'd0 || bus.abort !== 1'b0) begin
      fails++;
      $display("FAIL reset_release state=%0d abort=%b want 0/0", bus.state_out, bus.abort);
    end
  endtask

  task automatic test_write();
    clr();
    addr_phase(1'b0, 0);
    tests++;
    if (bus.state_out !== 4'd2 || bus.addr_we !== 1'b1) begin
      fails++;
      $display("FAIL wr_addr state=%0d addr_we=%b want 2/1", bus.state_out, bus.addr_we);
    end
    repeat (3) tick();
    tests++;
    if (bus.state_out !== 4'd6 || n_addr != 1) begin
      fails++;
      $display("FAIL wr_shift state=%0d n_addr=%0d want 6/1", bus.state_out, n_addr);
    end
    pulses(8, 1);
    tests++;
    if (bus.state_out !== 4'd7 || bus.dm_we !== 1'b1) begin
      fails++;
      $display("FAIL wr_commit state=%0d dm_we=%b want 7/1", bus.state_out, bus.dm_we);
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd8 || n_dm != 1) begin
      fails++;
      $display("FAIL wr_done state=%0d n_dm=%0d want 8/1", bus.state_out, n_dm);
    end
    bus.cs_cond = 1'b1;
    tick();
    tests++;
    if (bus.state_out !== 4'd0 || n_abort != 0 || n_sr != 0 || n_miso != 0) begin
      fails++;
      $display("FAIL wr_end state=%0d abort=%0d sr=%0d miso=%0d want 0/0/0/0", bus.state_out, n_abort, n_sr, n_miso);
    end
  endtask

  task automatic test_read();
    clr();
    addr_phase(1'b1, 2);
    tick();
    tests++;
    if (bus.state_out !== 4'd3 || bus.sr_we !== 1'b0) begin
      fails++;
      $display("FAIL rd_wait state=%0d sr_we=%b want 3/0", bus.state_out, bus.sr_we);
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd4 || bus.sr_we !== 1'b1) begin
      fails++;
      $display("FAIL rd_load state=%0d sr_we=%b want 4/1", bus.state_out, bus.sr_we);
    end
    tick();
    n_miso = 0;
    pulses(8, 0);
    tests++;
    if (bus.state_out !== 4'd8 || bus.miso_en !== 1'b0 || n_miso != 8) begin
      fails++;
      $display("FAIL rd_done state=%0d miso=%b n_miso=%0d want 8/0/8", bus.state_out, bus.miso_en, n_miso);
    end
    bus.cs_cond = 1'b1;
    tick();
    tests++;
    if (bus.state_out !== 4'd0 || n_sr != 1 || n_addr != 1 || n_dm != 0) begin
      fails++;
      $display("FAIL rd_end state=%0d sr=%0d addr=%0d dm=%0d want 0/1/1/0", bus.state_out, n_sr, n_addr, n_dm);
    end
  endtask

  task automatic test_abort();
    clr();
    addr_phase(1'b0, 0);
    repeat (3) tick();
    pulses(5, 0);
    bus.cs_cond = 1'b1;
    tick();
    tests++;
    if (bus.state_out !== 4'd0 || bus.abort !== 1'b1) begin
      fails++;
      $display("FAIL ab_pulse state=%0d abort=%b want 0/1", bus.state_out, bus.abort);
    end
    tick();
    tests++;
    if (bus.abort !== 1'b0 || n_abort != 1 || n_dm != 0) begin
      fails++;
      $display("FAIL ab_after abort=%b n_abort=%0d n_dm=%0d want 0/1/0", bus.abort, n_abort, n_dm);
    end
    addr_phase(1'b0, 0);
    tests++;
    if (bus.state_out !== 4'd2) begin
      fails++;
      $display("FAIL ab_next state=%0d want 2", bus.state_out);
    end
    bus.cs_cond = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_boundary();
    clr();
    addr_phase(1'b0, 0);
    repeat (3) tick();
    pulses(7, 0);
    bus.sclk_pos = 1'b1;
    bus.cs_cond  = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    tests++;
    if (bus.state_out !== 4'd0 || bus.abort !== 1'b1 || bus.dm_we !== 1'b0) begin
      fails++;
      $display("FAIL bd_8th state=%0d abort=%b dm=%b want 0/1/0", bus.state_out, bus.abort, bus.dm_we);
    end
    tick();
    tests++;
    if (n_dm != 0 || n_abort != 1) begin
      fails++;
      $display("FAIL bd_8th_cnt n_dm=%0d n_abort=%0d want 0/1", n_dm, n_abort);
    end
    clr();
    addr_phase(1'b0, 1);
    repeat (3) tick();
    pulses(8, 0);
    bus.cs_cond = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.state_out !== 4'd0 || n_dm != 1 || n_abort != 0) begin
      fails++;
      $display("FAIL bd_commit state=%0d n_dm=%0d n_abort=%0d want 0/1/0", bus.state_out, n_dm, n_abort);
    end
  endtask

  task automatic test_noise();
    clr();
    bus.cs_cond = 1'b1;
    pulses(4, 1);
    tests++;
    if (bus.state_out !== 4'd0 || n_abort != 0) begin
      fails++;
      $display("FAIL nz_idle state=%0d abort=%0d want 0/0", bus.state_out, n_abort);
    end
    addr_phase(1'b1, 0);
    tick();
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    tests++;
    if (bus.state_out !== 4'd4) begin
      fails++;
      $display("FAIL nz_wait state=%0d want 4", bus.state_out);
    end
    tick();
    n_miso = 0;
    pulses(8, 0);
    tests++;
    if (bus.state_out !== 4'd8 || n_miso != 8) begin
      fails++;
      $display("FAIL nz_count state=%0d n_miso=%0d want 8/8", bus.state_out, n_miso);
    end
    pulses(3, 0);
    tests++;
    if (bus.state_out !== 4'd8 || n_miso != 8) begin
      fails++;
      $display("FAIL nz_done state=%0d n_miso=%0d want 8/8", bus.state_out, n_miso);
    end
    bus.cs_cond = 1'b1;
    tick();
    tests++;
    if (bus.state_out !== 4'd0 || n_abort != 0) begin
      fails++;
      $display("FAIL nz_end state=%0d abort=%0d want 0/0", bus.state_out, n_abort);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic rd;
      int gap, mode, phase, k, j, e_addr, e_sr, e_dm, e_miso, e_abort;
      logic coinc;
      rd    = 1'($urandom % 2);
      gap   = int'($urandom % 3);
      mode  = int'($urandom % 4);
      phase = int'($urandom % 3);
      k     = int'($urandom % 8);
      coinc = 1'($urandom % 2);
      clr();
      if (mode != 0 && phase == 0) begin
        bus.cs_cond = 1'b0;
        bus.rw_bit  = 1'($urandom % 2);
        tick();
        pulses(k, gap);
        bus.sclk_pos = coinc;
        bus.cs_cond  = 1'b1;
        tick();
        bus.sclk_pos = 1'b0;
        e_addr = 0; e_sr = 0; e_dm = 0; e_miso = 0; e_abort = 1;
      end else begin
        addr_phase(rd, gap);
        e_addr = 1;
        if (mode != 0 && phase == 1) begin
          j = k % 3;
          repeat (j) tick();
          bus.cs_cond = 1'b1;
          tick();
          e_sr = (rd && j == 2) ? 1 : 0;
          e_dm = 0; e_miso = 0; e_abort = 1;
        end else if (mode != 0) begin
          repeat (3) tick();
          pulses(k, gap);
          bus.sclk_pos = coinc;
          bus.cs_cond  = 1'b1;
          tick();
          bus.sclk_pos = 1'b0;
          e_sr   = rd ? 1 : 0;
          e_dm   = 0;
          e_miso = rd ? k * (gap + 1) + 1 : 0;
          e_abort = 1;
        end else begin
          repeat (3) tick();
          pulses(8, gap);
          if (!rd) tick();
          tests++;
          if (bus.state_out !== 4'd8) begin
            fails++;
            $display("FAIL rnd%0d_done state=%0d want 8", it, bus.state_out);
          end
          bus.cs_cond = 1'b1;
          tick();
          e_sr   = rd ? 1 : 0;
          e_dm   = rd ? 0 : 1;
          e_miso = rd ? 8 * (gap + 1) : 0;
          e_abort = 0;
        end
      end
      tick();
      tests++;
      if (bus.state_out !== 4'd0 || n_abort != e_abort || n_addr != e_addr) begin
        fails++;
        $display("FAIL rnd%0d_ctl state=%0d abort=%0d addr=%0d want 0/%0d/%0d", it, bus.state_out, n_abort, n_addr, e_abort, e_addr);
      end
      tests++;
      if (n_sr != e_sr || n_dm != e_dm || n_miso != e_miso) begin
        fails++;
        $display("FAIL rnd%0d_strb sr=%0d dm=%0d miso=%0d want %0d/%0d/%0d", it, n_sr, n_dm, n_miso, e_sr, e_dm, e_miso);
      end
    end
  endtask

  initial begin
    bus.sclk_pos = 1'b0;
    bus.cs_cond  = 1'b1;
    bus.rw_bit   = 1'b0;
    clr();
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_boundary();
    test_noise();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
